// File: rtl/seg7_word_decoder_if.sv
// seg7_word_decoder_if: seg/code valid-ready handshake bundle.
// The slave modport is the decoder view: it takes seg/seg_valid/code_ready and
// drives seg_ready/code/code_valid/bad. The master modport is the opposite side.
interface seg7_word_decoder_if;
  logic [0:6] seg;
  logic       seg_valid;
  logic       seg_ready;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       bad;
  modport slave (input seg, seg_valid, code_ready, output seg_ready, code, code_valid, bad);
  modport master (output seg, seg_valid, code_ready, input seg_ready, code, code_valid, bad);
endinterface

// File: rtl/seg7_word_decoder.sv
// seg7_word_decoder: decodes active-low 7-segment patterns into H/E/L/O codes and spots the word HELLO.
// Ports: Clock_i rising-edge clock; Resetn_i synchronous active-low reset;
//   bus (slave) seg/code handshake; word_found_o one-cycle pulse per HELLO;
//   word_cnt_o saturating word count, present only with SEG7_WORD_CNT_EN defined (else 0).
module seg7_word_decoder (
  input  logic                      Clock_i,
  input  logic                      Resetn_i,
  seg7_word_decoder_if.slave        bus,
  output logic                      word_found_o,
  output logic [3:0]                word_cnt_o
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_H    = 3'd1;
  localparam logic [2:0] S_HE   = 3'd2;
  localparam logic [2:0] S_HEL  = 3'd3;
  localparam logic [2:0] S_HELL = 3'd4;
  localparam logic [2:0] C_H = 3'd0;
  localparam logic [2:0] C_E = 3'd1;
  localparam logic [2:0] C_L = 3'd2;
  localparam logic [2:0] C_O = 3'd3;
  localparam logic [2:0] C_X = 3'd7;
  logic [2:0] state_q, state_d;
  logic [2:0] code_q, dec;
  logic       bad_q, valid_q, found_q;
  logic       xfer, done;
  // Patterns are written seg[0..6] left to right, so seg[0] (a) is the MSB of each literal.
  assign dec = bus.seg == 7'b1001000 ? C_H :
               bus.seg == 7'b0110000 ? C_E :
               bus.seg == 7'b1110001 ? C_L :
               bus.seg == 7'b0000001 ? C_O : C_X;
  assign bus.seg_ready  = !valid_q || bus.code_ready;
  assign xfer           = bus.seg_valid && bus.seg_ready;
  assign bus.code       = code_q;
  assign bus.bad        = bad_q;
  assign bus.code_valid = valid_q;
  assign word_found_o   = found_q;
  assign done = xfer && state_q == S_HELL && dec == C_O;
  // An H restarts the word from any state; anything off-sequence drops to idle.
  always_comb begin
    state_d = !xfer                         ? state_q :
              dec == C_H                    ? S_H     :
              state_q == S_H   && dec == C_E ? S_HE   :
              state_q == S_HE  && dec == C_L ? S_HEL  :
              state_q == S_HEL && dec == C_L ? S_HELL : S_IDLE;
  end
  always_ff @(posedge Clock_i) begin
    if (!Resetn_i) begin
      state_q <= S_IDLE;
      code_q  <= 3'd0;
      bad_q   <= 1'b0;
      valid_q <= 1'b0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      found_q <= done;
      if (xfer) begin
        code_q  <= dec;
        bad_q   <= dec == C_X;
        valid_q <= 1'b1;
      end else if (bus.code_ready) begin
        valid_q <= 1'b0;
      end
    end
  end
`ifdef SEG7_WORD_CNT_EN
  logic [3:0] cnt_q;
  always_ff @(posedge Clock_i) begin
    if (!Resetn_i) cnt_q <= 4'd0;
    else if (done && cnt_q != 4'd15) cnt_q <= cnt_q + 4'd1;
  end
  assign word_cnt_o = cnt_q;
`else
  assign word_cnt_o = 4'd0;
`endif
endmodule
